pp_adder_pipe: RTL and testbench

Parametrised, two-stage pipelined ripple-carry adder with parity prediction, continuous self-checking and error logging, for the dependable-computing datapath. It generalises the 3-bit parity-predicted adder to WIDTH bits. It adds a valid/ready handshake, sticky error flags, a saturating error counter and a fault-injection port for verifying the checker. It sits between operand sources that carry one odd-parity bit per operand pair and consumers that need a checked sum plus its parity.

---
 rtl/pp_adder_pipe_pkg.sv | 10 +
 rtl/pp_adder_pipe_if.sv | 31 +++
 rtl/pp_carry_chain.sv | 19 +
 rtl/pp_adder_pipe.sv | 100 ++++++++++
 tb/tb_pp_adder_pipe.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pp_adder_pipe_pkg.sv
// pp_adder_pipe_pkg: shared odd-parity helper and err_flags bit indices
package pp_adder_pipe_pkg;
    localparam int IN_PERR   = 0;
    localparam int OUT_PERR  = 1;
    localparam int PAR_MAX_W = 64;
    // True when the XOR over all bits is 1; zero-extending a narrower word leaves the result unchanged.
    function automatic logic odd_ok(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/pp_adder_pipe_if.sv
// pp_adder_pipe_if: operand/result handshake, fault injection and error-log signals.
// master = operand source / result consumer, slave = the adder pipeline.
interface pp_adder_pipe_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 cin;
    logic                 par_in;
    logic [WIDTH-1:0]     inj_mask;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     s;
    logic                 cout;
    logic                 par_out;
    logic                 error_out;
    logic [1:0]           err_flags;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 err_clr;
    modport master (
        output in_valid, a, b, cin, par_in, inj_mask, out_ready, err_clr,
        input  in_ready, out_valid, s, cout, par_out, error_out, err_flags, err_count
    );
    modport slave (
        input  in_valid, a, b, cin, par_in, inj_mask, out_ready, err_clr,
        output in_ready, out_valid, s, cout, par_out, error_out, err_flags, err_count
    );
endinterface

// File: rtl/pp_carry_chain.sv
// pp_carry_chain: ripple carry vector for parity prediction.
// Ports: a_i, b_i, cin_i operands; c_o[i] = carry into bit i (c_o[0] = cin_i); cout_o = carry out of the MSB.
module pp_carry_chain #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] c_o,
    output logic             cout_o
);
    logic [WIDTH:0] k;
    always_comb begin
        k[0] = cin_i;
        for (int i = 0; i < WIDTH; i++) k[i+1] = (a_i[i] & b_i[i]) | ((a_i[i] | b_i[i]) & k[i]);
    end
    assign c_o    = k[WIDTH-1:0];
    assign cout_o = k[WIDTH];
endmodule

// File: rtl/pp_adder_pipe.sv
// pp_adder_pipe: two-stage parity-predicted adder with self-check, sticky flags and saturating error counter.
// Ports: clk_50 clock, reset_l async active-low reset, bus (slave) carrying operands, handshakes,
// fault-injection mask, checked sum with predicted parity, error flags/counter and their clear.
module pp_adder_pipe
    import pp_adder_pipe_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input logic            clk_50,
    input logic            reset_l,
    pp_adder_pipe_if.slave bus
);
    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 cin_q, cin_d, par_q, par_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic                 cout_q, cout_d, par_out_q, par_out_d;
    logic [1:0]           perr_q, perr_d, flags_q, flags_d, new_err;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 ld1, ld2, acc, mv, hs;
    logic [WIDTH-1:0]     carry, sum, s_new;
    logic                 chain_cout, p_new;

    pp_carry_chain #(.WIDTH(WIDTH)) u_chain (
        .a_i   (a_q),
        .b_i   (b_q),
        .cin_i (cin_q),
        .c_o   (carry),
        .cout_o(chain_cout)
    );

    assign ld2 = !out_valid_q || bus.out_ready;
    assign ld1 = !s1_valid_q || ld2;
    assign acc = ld1 && bus.in_valid;
    assign mv  = ld2 && s1_valid_q;
    assign hs  = out_valid_q && bus.out_ready;
    // Sum comes from a separate adder so a single fault in either chain shows up as a parity mismatch.
    assign sum = a_q + b_q + WIDTH'(cin_q);

    always_comb begin
        s_new             = sum ^ bus.inj_mask;
        p_new             = par_q ^ (^carry);
        new_err           = '0;
        new_err[IN_PERR]  = !odd_ok(PAR_MAX_W'({a_q, b_q, par_q}));
        new_err[OUT_PERR] = !odd_ok(PAR_MAX_W'({s_new, p_new}));
        s1_valid_d        = ld1 ? bus.in_valid : s1_valid_q;
        a_d               = acc ? bus.a : a_q;
        b_d               = acc ? bus.b : b_q;
        cin_d             = acc ? bus.cin : cin_q;
        par_d             = acc ? bus.par_in : par_q;
        out_valid_d       = ld2 ? s1_valid_q : out_valid_q;
        s_d               = mv ? s_new : s_q;
        cout_d            = mv ? chain_cout : cout_q;
        par_out_d         = mv ? p_new : par_out_q;
        perr_d            = mv ? new_err : perr_q;
        flags_d           = bus.err_clr ? '0 : hs ? (flags_q | perr_q) : flags_q;
        cnt_d             = bus.err_clr ? '0 : (hs && |perr_q && !(&cnt_q)) ? cnt_q + ERR_CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk_50 or negedge reset_l) begin
        if (!reset_l) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            par_q       <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            par_out_q   <= 1'b1;
            perr_q      <= '0;
            flags_q     <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            par_q       <= par_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            par_out_q   <= par_out_d;
            perr_q      <= perr_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = ld1;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.par_out   = par_out_q;
    assign bus.error_out = |perr_q;
    assign bus.err_flags = flags_q;
    assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_pp_adder_pipe.sv
// tb_pp_adder_pipe: randomized and directed checks of pp_adder_pipe against an arithmetic reference model
module tb_pp_adder_pipe;
    typedef struct packed {
        logic [7:0] s;
        logic       cout;
        logic       par;
        logic       err;
        logic       ip;
        logic       op;
    } beat_t;

    logic clk_50 = 1'b0;
    logic reset_l;
    int   checks = 0;
    int   passed = 0;
    beat_t pipe_q[$];
    beat_t exp_q[$];
    beat_t got_q[$];
    logic [1:0] mflags = '0;
    int   mcnt8 = 0;
    int   mcnt2 = 0;

    always #5 clk_50 = ~clk_50;

    pp_adder_pipe_if #(.WIDTH(8), .ERR_CNT_W(8)) bus8 ();
    pp_adder_pipe_if #(.WIDTH(8), .ERR_CNT_W(2)) bus2 ();

    assign bus2.in_valid  = bus8.in_valid;
    assign bus2.a         = bus8.a;
    assign bus2.b         = bus8.b;
    assign bus2.cin       = bus8.cin;
    assign bus2.par_in    = bus8.par_in;
    assign bus2.inj_mask  = bus8.inj_mask;
    assign bus2.out_ready = bus8.out_ready;
    assign bus2.err_clr   = bus8.err_clr;

    pp_adder_pipe #(.WIDTH(8), .ERR_CNT_W(8)) dut8 (.clk_50(clk_50), .reset_l(reset_l), .bus(bus8));
    pp_adder_pipe #(.WIDTH(8), .ERR_CNT_W(2)) dut2 (.clk_50(clk_50), .reset_l(reset_l), .bus(bus2));

    // Carries recovered arithmetically: each sum bit is a ^ b ^ carry-in of that bit.
    function automatic beat_t ref_beat(logic [7:0] a, logic [7:0] b, logic cin, logic par, logic [7:0] m);
        beat_t r;
        logic [8:0] full;
        logic [7:0] carries;
        full    = {1'b0, a} + {1'b0, b} + 9'(cin);
        carries = a ^ b ^ full[7:0];
        r.s     = full[7:0] ^ m;
        r.cout  = full[8];
        r.par   = par ^ (^carries);
        r.ip    = ~(^{a, b, par});
        r.op    = ~(^{r.s, r.par});
        r.err   = r.ip | r.op;
        return r;
    endfunction

    task automatic rand_beat(input bit bad);
        bus8.a      = 8'($urandom);
        bus8.b      = 8'($urandom);
        bus8.cin    = 1'($urandom);
        bus8.par_in = bad ? ^{bus8.a, bus8.b} : ~(^{bus8.a, bus8.b});
    endtask

    // Advances one clock, updating the reference model with the handshakes about to happen.
    task automatic cycle();
        beat_t e;
        #1;
        if (bus8.out_valid && bus8.out_ready) begin
            if (pipe_q.size() == 0) begin
                checks++;
                $display("FAIL spurious_beat: out_valid=1 s=%h with no beat in flight", bus8.s);
            end else begin
                e = pipe_q.pop_front();
                exp_q.push_back(e);
                got_q.push_back('{s: bus8.s, cout: bus8.cout, par: bus8.par_out, err: bus8.error_out, ip: 1'b0, op: 1'b0});
                if (!bus8.err_clr) begin
                    mflags |= {e.op, e.ip};
                    if (e.err) begin
                        mcnt8 = (mcnt8 < 255) ? mcnt8 + 1 : 255;
                        mcnt2 = (mcnt2 < 3) ? mcnt2 + 1 : 3;
                    end
                end
            end
        end
        if (bus8.err_clr) begin
            mflags = '0;
            mcnt8  = 0;
            mcnt2  = 0;
        end
        if (bus8.in_valid && bus8.in_ready)
            pipe_q.push_back(ref_beat(bus8.a, bus8.b, bus8.cin, bus8.par_in, bus8.inj_mask));
        @(posedge clk_50);
        @(negedge clk_50);
    endtask

    task automatic test_reset();
        reset_l        = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.cin       = 1'b0;
        bus8.par_in    = 1'b0;
        bus8.inj_mask  = '0;
        bus8.out_ready = 1'b1;
        bus8.err_clr   = 1'b0;
        repeat (2) @(negedge clk_50);
        checks++;
        if ({bus8.out_valid, bus8.error_out, bus2.out_valid} !== 3'b000)
            $display("FAIL reset_valid: out_valid=%b error_out=%b out_valid2=%b, expected 0 0 0", bus8.out_valid, bus8.error_out, bus2.out_valid);
        else passed++;
        checks++;
        if ({bus8.s, bus8.cout, bus8.par_out} !== {8'h00, 1'b0, 1'b1})
            $display("FAIL reset_data: s=%h cout=%b par_out=%b, expected 00 0 1", bus8.s, bus8.cout, bus8.par_out);
        else passed++;
        checks++;
        if ({bus8.err_flags, bus8.err_count, bus2.err_count} !== 12'h000)
            $display("FAIL reset_errlog: flags=%b count=%0d count2=%0d, expected 0 0 0", bus8.err_flags, bus8.err_count, bus2.err_count);
        else passed++;
        reset_l = 1'b1;
        @(negedge clk_50);
        checks++;
        if (bus8.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, expected 1", bus8.in_ready);
        else passed++;
    endtask

    task automatic test_vec(input string name, input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic par, input logic [7:0] mask, input logic [7:0] es, input logic ec,
                            input logic ep, input logic ee, input logic [1:0] ef, input int ecnt);
        bus8.err_clr = 1'b1;
        cycle();
        bus8.err_clr   = 1'b0;
        bus8.inj_mask  = mask;
        bus8.a         = a;
        bus8.b         = b;
        bus8.cin       = cin;
        bus8.par_in    = par;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        cycle();
        bus8.in_valid = 1'b0;
        checks++;
        if (bus8.out_valid !== 1'b0) $display("FAIL %s_latency: out_valid=%b one cycle after accept, expected 0", name, bus8.out_valid);
        else passed++;
        cycle();
        checks++;
        if (bus8.out_valid !== 1'b1) $display("FAIL %s_present: out_valid=%b two cycles after accept, expected 1", name, bus8.out_valid);
        else passed++;
        checks++;
        if ({bus8.s, bus8.cout, bus8.par_out, bus8.error_out} !== {es, ec, ep, ee})
            $display("FAIL %s_result: s=%h cout=%b par=%b err=%b, expected s=%h cout=%b par=%b err=%b",
                     name, bus8.s, bus8.cout, bus8.par_out, bus8.error_out, es, ec, ep, ee);
        else passed++;
        cycle();
        checks++;
        if ({bus8.err_flags, bus8.err_count, bus2.err_count} !== {ef, 8'(ecnt), 2'(ecnt)})
            $display("FAIL %s_errlog: flags=%b count=%0d count2=%0d, expected flags=%b count=%0d",
                     name, bus8.err_flags, bus8.err_count, bus2.err_count, ef, ecnt);
        else passed++;
        bus8.inj_mask = '0;
    endtask

    task automatic test_random_and_back_to_back();
        beat_t g, e;
        int stalls = 0;
        int n;
        for (int c = 0; c < 300; c++) begin
            bus8.in_valid  = ($urandom_range(0, 3) != 0);
            rand_beat($urandom_range(0, 3) == 0);
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            bus8.err_clr   = ($urandom_range(0, 39) == 0);
            cycle();
        end
        bus8.err_clr   = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 10 && pipe_q.size() > 0; i++) cycle();
        checks++;
        if (pipe_q.size() != 0) $display("FAIL random_drain: %0d beats never delivered, expected 0", pipe_q.size());
        else passed++;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if ({g.s, g.cout, g.par, g.err} !== {e.s, e.cout, e.par, e.err})
                $display("FAIL random_beat: got s=%h cout=%b par=%b err=%b, expected s=%h cout=%b par=%b err=%b",
                         g.s, g.cout, g.par, g.err, e.s, e.cout, e.par, e.err);
            else passed++;
        end
        checks++;
        if ({bus8.err_flags, bus8.err_count, bus2.err_count} !== {mflags, 8'(mcnt8), 2'(mcnt2)})
            $display("FAIL random_errlog: flags=%b count=%0d count2=%0d, expected flags=%b count=%0d count2=%0d",
                     bus8.err_flags, bus8.err_count, bus2.err_count, mflags, mcnt8, mcnt2);
        else passed++;
        bus8.in_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            rand_beat(1'b0);
            #1;
            if (!bus8.in_ready) stalls++;
            cycle();
        end
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 10 && pipe_q.size() > 0; i++) cycle();
        checks++;
        if (stalls != 0) $display("FAIL b2b_in_ready: in_ready low on %0d cycles, expected 0", stalls);
        else passed++;
        n = got_q.size();
        checks++;
        if (n != 16) $display("FAIL b2b_count: delivered %0d beats, expected 16", n);
        else passed++;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if ({g.s, g.cout, g.par, g.err} !== {e.s, e.cout, e.par, e.err})
                $display("FAIL b2b_beat: got s=%h cout=%b par=%b err=%b, expected s=%h cout=%b par=%b err=%b",
                         g.s, g.cout, g.par, g.err, e.s, e.cout, e.par, e.err);
            else passed++;
        end
    endtask

    task automatic test_stall();
        beat_t g, e;
        int acc = 0;
        logic took;
        logic [7:0] held_s;
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        rand_beat(1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            took = bus8.in_ready;
            checks++;
            if (took !== (acc < 2)) $display("FAIL stall_in_ready: cycle %0d in_ready=%b after %0d accepts", c, took, acc);
            else passed++;
            if (took) acc++;
            cycle();
            if (took) rand_beat($urandom_range(0, 1) == 0);
            if (c == 1) held_s = bus8.s;
        end
        checks++;
        if ({bus8.out_valid, bus8.s} !== {1'b1, held_s})
            $display("FAIL stall_hold: out_valid=%b s=%h, expected 1 %h", bus8.out_valid, bus8.s, held_s);
        else passed++;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 5 && acc < 3; i++) begin
            #1;
            took = bus8.in_ready;
            cycle();
            if (took) acc++;
        end
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 10 && pipe_q.size() > 0; i++) cycle();
        checks++;
        if (got_q.size() != 3) $display("FAIL stall_count: delivered %0d beats, expected 3", got_q.size());
        else passed++;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if ({g.s, g.cout, g.par, g.err} !== {e.s, e.cout, e.par, e.err})
                $display("FAIL stall_beat: got s=%h cout=%b par=%b err=%b, expected s=%h cout=%b par=%b err=%b",
                         g.s, g.cout, g.par, g.err, e.s, e.cout, e.par, e.err);
            else passed++;
        end
    endtask

    task automatic test_saturate_and_clear();
        bus8.err_clr = 1'b1;
        cycle();
        bus8.err_clr   = 1'b0;
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rand_beat(1'b1);
            cycle();
        end
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 10 && pipe_q.size() > 0; i++) cycle();
        checks++;
        if (bus2.err_count !== 2'd3) $display("FAIL sat_count2: err_count=%0d, expected 3", bus2.err_count);
        else passed++;
        checks++;
        if (bus8.err_count !== 8'd5) $display("FAIL sat_count8: err_count=%0d, expected 5", bus8.err_count);
        else passed++;
        checks++;
        if ({bus8.err_flags, bus2.err_count} !== {mflags, 2'(mcnt2)})
            $display("FAIL sat_model: flags=%b count2=%0d, expected flags=%b count2=%0d", bus8.err_flags, bus2.err_count, mflags, mcnt2);
        else passed++;
        bus8.in_valid = 1'b1;
        rand_beat(1'b1);
        cycle();
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 5 && !bus8.out_valid; i++) cycle();
        checks++;
        if ({bus8.out_valid, bus8.error_out} !== 2'b11)
            $display("FAIL clr_beat_ready: out_valid=%b error_out=%b, expected 1 1", bus8.out_valid, bus8.error_out);
        else passed++;
        bus8.err_clr = 1'b1;
        cycle();
        bus8.err_clr = 1'b0;
        checks++;
        if ({bus8.err_flags, bus8.err_count, bus2.err_count} !== 12'h000)
            $display("FAIL clr_priority: flags=%b count=%0d count2=%0d, expected 0 0 0", bus8.err_flags, bus8.err_count, bus2.err_count);
        else passed++;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_midreset();
        beat_t g, e;
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_beat(1'b1);
            cycle();
        end
        checks++;
        if (bus8.out_valid !== 1'b1) $display("FAIL midrst_filled: out_valid=%b before reset, expected 1", bus8.out_valid);
        else passed++;
        #2;
        reset_l = 1'b0;
        #1;
        checks++;
        if ({bus8.out_valid, bus2.out_valid, bus8.error_out, bus8.s} !== 11'h0)
            $display("FAIL midrst_clear: out_valid=%b out_valid2=%b error_out=%b s=%h, expected all 0",
                     bus8.out_valid, bus2.out_valid, bus8.error_out, bus8.s);
        else passed++;
        checks++;
        if ({bus8.in_ready, bus8.err_count, bus2.err_count} !== {1'b1, 8'h00, 2'b00})
            $display("FAIL midrst_state: in_ready=%b count=%0d count2=%0d, expected 1 0 0", bus8.in_ready, bus8.err_count, bus2.err_count);
        else passed++;
        pipe_q.delete();
        got_q.delete();
        exp_q.delete();
        mflags = '0;
        mcnt8  = 0;
        mcnt2  = 0;
        bus8.in_valid = 1'b0;
        @(negedge clk_50);
        reset_l        = 1'b1;
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rand_beat($urandom_range(0, 1) == 0);
            cycle();
        end
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 10 && pipe_q.size() > 0; i++) cycle();
        checks++;
        if (got_q.size() != 4) $display("FAIL midrst_after: delivered %0d beats, expected 4", got_q.size());
        else passed++;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if ({g.s, g.cout, g.par, g.err} !== {e.s, e.cout, e.par, e.err})
                $display("FAIL midrst_beat: got s=%h cout=%b par=%b err=%b, expected s=%h cout=%b par=%b err=%b",
                         g.s, g.cout, g.par, g.err, e.s, e.cout, e.par, e.err);
            else passed++;
        end
        checks++;
        if ({bus8.err_flags, bus8.err_count, bus2.err_count} !== {mflags, 8'(mcnt8), 2'(mcnt2)})
            $display("FAIL midrst_errlog: flags=%b count=%0d count2=%0d, expected flags=%b count=%0d count2=%0d",
                     bus8.err_flags, bus8.err_count, bus2.err_count, mflags, mcnt8, mcnt2);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_vec("basic",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 2'b00, 0);
        test_vec("carry",  8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 2'b00, 0);
        test_vec("badpar", 8'h0F, 8'h01, 1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b1, 1'b1, 2'b11, 1);
        test_vec("inject", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h01, 8'h11, 1'b0, 1'b0, 1'b1, 2'b10, 1);
        test_random_and_back_to_back();
        test_stall();
        test_saturate_and_clear();
        test_midreset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
